// File: rtl/step_decoder_pkg.sv
// Shared types and default sizes for the step/dir decoder.
package stepgen_pkg;

    localparam int W_DEF = 16;
    localparam int T_DEF = 5;
    localparam int P_DEF = 16;

    // Direction settle FSM encoding
    typedef enum logic {
        SETTLE = 1'b0,
        READY  = 1'b1
    } dir_state_t;

endpackage

// File: rtl/step_decoder_sig_filter.sv
// Two-flop synchronizer followed by a consecutive-sample glitch filter.
// The filtered level only follows the synchronized input after the input
// has disagreed with it for filt_len+1 clocks in a row.
module sig_filter #(
    parameter int T = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         raw,
    input  logic [T-1:0] filt_len,
    output logic         level
);

    logic         sync1;
    logic         sync2;
    logic [T-1:0] count;

    // Synchronizers run regardless of enable; the filter count freezes when disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            count <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (enable) begin
                if (sync2 != level) begin
                    if (count == filt_len) begin
                        level <= sync2;
                        count <= '0;
                    end else begin
                        count <= count + T'(1);
                    end
                end else begin
                    count <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/step_decoder.sv
// Step/direction decoder: filtered step edges move a signed position
// counter, the interval between steps is measured, and dir setup/hold
// violations are latched in err_dir.
//
// Dir FSM
//   state  | meaning
//   SETTLE | filtered dir changed recently; setup window still counting down
//   READY  | dir has been stable for at least dirtime clocks
module step_decoder
    import stepgen_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int T = T_DEF,
    parameter int P = P_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         step_in,
    input  logic         dir_in,
    input  logic         step_pol,
    input  logic [T-1:0] filt_len,
    input  logic [T-1:0] dirtime,
    input  logic         err_clr,
    output logic [W-1:0] position,
    output logic [P-1:0] period,
    output logic         period_valid,
    output logic         step_evt,
    output logic         err_dir
);

    logic         step_f;
    logic         dir_f;
    logic         step_prev;
    logic         dir_prev;
    dir_state_t   state;
    logic [T-1:0] settle_cnt;
    logic [P-1:0] per_cnt;
    logic         seen_one;

    logic         active_lvl;
    logic         edge_hit;
    logic         dir_chg;
    logic         setup_err;
    logic         hold_err;
    logic         per_sat;

    sig_filter #(.T(T)) u_step_filt (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .raw      (step_in),
        .filt_len (filt_len),
        .level    (step_f)
    );

    sig_filter #(.T(T)) u_dir_filt (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .raw      (dir_in),
        .filt_len (filt_len),
        .level    (dir_f)
    );

    // Edge and violation detection on the filtered signals.
    // A dir change in the same cycle as the edge counts as zero setup.
    // The settle count includes the change cycle itself, hence the >1 test.
    always_comb begin
        active_lvl = ~step_pol;
        edge_hit   = (step_f != step_prev) && (step_f == active_lvl);
        dir_chg    = (dir_f != dir_prev);
        setup_err  = edge_hit &&
                     ((dir_chg && (dirtime != '0)) ||
                      ((state == SETTLE) && (settle_cnt > T'(1))));
        hold_err   = dir_chg && (step_prev == active_lvl) && (step_f == active_lvl);
        per_sat    = (per_cnt == '1);
    end

    // Step pipeline: previous filtered levels, step pulse and position count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_prev <= 1'b0;
            dir_prev  <= 1'b0;
            step_evt  <= 1'b0;
            position  <= '0;
        end else begin
            step_evt <= 1'b0;
            if (enable) begin
                step_prev <= step_f;
                dir_prev  <= dir_f;
                if (edge_hit) begin
                    step_evt <= 1'b1;
                    position <= dir_f ? position + W'(1) : position - W'(1);
                end
            end
        end
    end

    // Dir settle FSM and sticky error flag; a new violation beats err_clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= READY;
            settle_cnt <= '0;
            err_dir    <= 1'b0;
        end else if (enable) begin
            if (dir_chg) begin
                state      <= SETTLE;
                settle_cnt <= dirtime;
            end else if (state == SETTLE) begin
                if (settle_cnt <= T'(1)) begin
                    state      <= READY;
                    settle_cnt <= '0;
                end else begin
                    settle_cnt <= settle_cnt - T'(1);
                end
            end
            if (setup_err || hold_err) begin
                err_dir <= 1'b1;
            end else if (err_clr) begin
                err_dir <= 1'b0;
            end
        end
    end

    // Step period measurement; saturation invalidates it until two fresh steps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_cnt      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            seen_one     <= 1'b0;
        end else if (enable) begin
            if (edge_hit) begin
                period       <= per_sat ? '1 : per_cnt + P'(1);
                per_cnt      <= '0;
                period_valid <= seen_one && !per_sat;
                seen_one     <= 1'b1;
            end else if (per_sat) begin
                period_valid <= 1'b0;
                seen_one     <= 1'b0;
            end else begin
                per_cnt <= per_cnt + P'(1);
            end
        end
    end

endmodule

// File: tb/tb_step_decoder.sv
// Scoreboard bench for step_decoder: stimulus phases are pre-built as
// per-cycle waveforms, a reference model predicts every step pulse, and a
// monitor compares each observed pulse against the queue.
module tb_step_decoder;

    localparam int NMAX = 700;

    typedef struct {
        int          cyc;
        logic [15:0] pos;
        bit          err;
        logic [7:0]  per;
        bit          val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        step_in;
    logic        dir_in;
    logic        step_pol;
    logic [4:0]  filt_len;
    logic [4:0]  dirtime;
    logic        err_clr;
    logic [15:0] position;
    logic [7:0]  period;
    logic        period_valid;
    logic        step_evt;
    logic        err_dir;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit sw [NMAX];
    bit dw [NMAX];
    bit cw [NMAX];
    bit ds [NMAX];
    bit dd [NMAX];

    int cfg_L;
    int cfg_dt;
    bit cfg_pol;

    logic [15:0] fin_pos;
    bit          fin_err;
    bit          fin_val;
    logic [7:0]  fin_per;

    exp_t q[$];

    step_decoder #(.W(16), .T(5), .P(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .step_in      (step_in),
        .dir_in       (dir_in),
        .step_pol     (step_pol),
        .filt_len     (filt_len),
        .dirtime      (dirtime),
        .err_clr      (err_clr),
        .position     (position),
        .period       (period),
        .period_valid (period_valid),
        .step_evt     (step_evt),
        .err_dir      (err_dir)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every step pulse must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (step_evt === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_step_evt: got pulse expected none (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("evt_cycle", 32'(cyc), 32'(e.cyc));
                chk("evt_position", 32'(position), 32'(e.pos));
                chk("evt_err_dir", 32'(err_dir), 32'(e.err));
                chk("evt_period", 32'(period), 32'(e.per));
                chk("evt_period_valid", 32'(period_valid), 32'(e.val));
            end
        end
    end

    // Filtered level as seen at the decoder's edge-detect stage: a run of a
    // new level lasting filt_len+1 samples is accepted, visible filt_len+3
    // clocks after its first sample.
    function automatic void detect(input bit sel, input int n);
        bit w [NMAX];
        bit d [NMAX];
        bit f;
        int i;
        int j;
        int t;
        if (sel) w = dw; else w = sw;
        for (int k = 0; k < NMAX; k++) d[k] = 1'b0;
        f = 1'b0;
        i = 0;
        while (i < n) begin
            j = i;
            while (j < n && w[j] == w[i]) j++;
            if (w[i] != f && (j - i) >= cfg_L + 1) begin
                f = w[i];
                t = i + cfg_L + 3;
                for (int k = t; k < n; k++) d[k] = f;
            end
            i = j;
        end
        if (sel) dd = d; else ds = d;
    endfunction

    function automatic void build_expect(input int n, input int base);
        bit          act;
        bit          sp;
        bit          dp;
        bit          evt;
        bit          set;
        bit          seen;
        bit          err;
        bit          val;
        logic [15:0] pos;
        logic [7:0]  per;
        int          tdc;
        int          tprev;
        int          gap;
        exp_t        e;
        act   = !cfg_pol;
        seen  = 1'b0;
        err   = 1'b0;
        val   = 1'b0;
        pos   = 16'd0;
        per   = 8'd0;
        tdc   = -1000;
        tprev = -1;
        detect(1'b0, n);
        detect(1'b1, n);
        for (int k = 0; k < n; k++) begin
            sp  = (k > 0) ? ds[k-1] : 1'b0;
            dp  = (k > 0) ? dd[k-1] : 1'b0;
            evt = (ds[k] != sp) && (ds[k] == act);
            set = (dd[k] != dp) && (sp == act) && (ds[k] == act);
            if (dd[k] != dp) tdc = k;
            if (evt) begin
                if (k - tdc < cfg_dt) set = 1'b1;
                pos = dd[k] ? pos + 16'd1 : pos - 16'd1;
                gap = k - tprev;
                if (gap - 1 >= 255) begin
                    per = 8'd255;
                    val = 1'b0;
                end else begin
                    per = 8'(gap);
                    val = seen;
                end
                seen  = 1'b1;
                tprev = k;
            end else if (k - tprev - 1 >= 255) begin
                val  = 1'b0;
                seen = 1'b0;
            end
            if (set) err = 1'b1;
            else if (cw[k]) err = 1'b0;
            if (evt) begin
                e.cyc = base + k;
                e.pos = pos;
                e.err = err;
                e.per = per;
                e.val = val;
                q.push_back(e);
            end
        end
        fin_pos = pos;
        fin_err = err;
        fin_val = val;
        fin_per = per;
    endfunction

    task automatic clear_waves();
        for (int k = 0; k < NMAX; k++) begin
            sw[k] = 1'b0;
            dw[k] = 1'b0;
            cw[k] = 1'b0;
        end
    endtask

    task automatic set_step(input int from, input int to);
        for (int k = from; k <= to; k++) sw[k] = 1'b1;
    endtask

    task automatic set_dir(input int from, input int to, input bit v);
        for (int k = from; k <= to; k++) dw[k] = v;
    endtask

    task automatic fill_random(input int n);
        int i;
        int len;
        bit lv;
        i  = 0;
        lv = 1'b0;
        while (i < n - 30) begin
            if ($urandom_range(0, 2) == 0) len = int'($urandom_range(1, cfg_L + 1));
            else len = int'($urandom_range(cfg_L + 1, cfg_L + 25));
            for (int k = 0; k < len && i < n; k++) begin
                sw[i] = lv;
                i++;
            end
            lv = !lv;
        end
        i  = 0;
        lv = 1'b0;
        while (i < n - 30) begin
            len = int'($urandom_range(2, 60));
            for (int k = 0; k < len && i < n; k++) begin
                dw[i] = lv;
                i++;
            end
            lv = !lv;
        end
        for (int k = 0; k < n; k++) cw[k] = ($urandom_range(0, 39) == 0);
        for (int k = n - 30; k < n; k++) begin
            sw[k] = sw[n-31];
            dw[k] = dw[n-31];
            cw[k] = 1'b0;
        end
    endtask

    task automatic do_reset(input int l, input int dt, input bit pol);
        @(negedge clk);
        rst_n    = 1'b0;
        enable   = 1'b1;
        step_in  = 1'b0;
        dir_in   = 1'b0;
        err_clr  = 1'b0;
        cfg_L    = l;
        cfg_dt   = dt;
        cfg_pol  = pol;
        filt_len = 5'(l);
        dirtime  = 5'(dt);
        step_pol = pol;
        @(negedge clk);
        chk("rst_position", 32'(position), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_period_valid", 32'(period_valid), 32'd0);
        chk("rst_step_evt", 32'(step_evt), 32'd0);
        chk("rst_err_dir", 32'(err_dir), 32'd0);
        rst_n = 1'b1;
    endtask

    // Plays the prepared waveforms starting at the current falling edge.
    task automatic play(input int n);
        build_expect(n, cyc + 1);
        for (int i = 0; i < n; i++) begin
            step_in = sw[i];
            dir_in  = dw[i];
            err_clr = cw[i];
            @(negedge clk);
        end
        err_clr = 1'b0;
        chk("end_position", 32'(position), 32'(fin_pos));
        chk("end_err_dir", 32'(err_dir), 32'(fin_err));
        chk("end_period", 32'(period), 32'(fin_per));
        chk("end_period_valid", 32'(period_valid), 32'(fin_val));
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        step_in  = 1'b0;
        dir_in   = 1'b0;
        err_clr  = 1'b0;
        step_pol = 1'b0;
        filt_len = 5'd0;
        dirtime  = 5'd0;
        cfg_L    = 0;
        cfg_dt   = 0;
        cfg_pol  = 1'b0;
        repeat (2) @(negedge clk);

        // 8-clock pulse with filt_len=2: pulse 5 clocks after first sample
        do_reset(2, 0, 1'b0);
        clear_waves();
        set_dir(0, 59, 1'b1);
        set_step(20, 27);
        play(60);
        chk("single_step_position", 32'(position), 32'd1);

        // 3-clock glitch rejected, 4-clock pulse accepted with filt_len=3
        do_reset(3, 0, 1'b0);
        clear_waves();
        set_dir(0, 79, 1'b1);
        set_step(20, 22);
        set_step(40, 43);
        play(80);
        chk("glitch_then_pulse_position", 32'(position), 32'd1);

        // Wrap: 0 -> FFFF -> 0 -> FFFF
        do_reset(1, 0, 1'b0);
        clear_waves();
        set_step(10, 15);
        set_dir(20, 59, 1'b1);
        set_step(40, 45);
        set_step(80, 85);
        play(120);
        chk("wrap_position", 32'(position), 32'hFFFF);

        // Setup violations with dirtime=4, err_clr racing a new violation
        do_reset(1, 4, 1'b0);
        clear_waves();
        set_dir(0, 27, 1'b1);
        set_step(30, 35);
        cw[50] = 1'b1;
        set_dir(70, 119, 1'b1);
        set_step(72, 77);
        cw[76] = 1'b1;
        play(120);
        chk("setup_err_sticky", 32'(err_dir), 32'd1);

        // Period: 100-clock gaps, then a 300-clock gap that saturates P=8
        do_reset(0, 0, 1'b0);
        clear_waves();
        set_dir(0, 599, 1'b1);
        set_step(10, 14);
        set_step(110, 114);
        set_step(210, 214);
        set_step(510, 514);
        set_step(560, 564);
        play(600);

        // Randomized phases
        for (int r = 0; r < 6; r++) begin
            do_reset(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            clear_waves();
            fill_random(500);
            play(500);
        end

        // enable=0 freezes the filters: a pulse fully inside the window is lost
        do_reset(2, 0, 1'b0);
        enable  = 1'b0;
        step_in = 1'b1;
        repeat (10) @(negedge clk);
        step_in = 1'b0;
        repeat (6) @(negedge clk);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        chk("enable_hold_position", 32'(position), 32'd0);
        chk("enable_hold_period", 32'(period), 32'd0);

        // One step down, then reset in the middle of a filter count
        do_reset(4, 0, 1'b0);
        clear_waves();
        set_step(5, 14);
        play(50);
        step_in = 1'b1;
        repeat (4) @(negedge clk);
        rst_n   = 1'b0;
        step_in = 1'b0;
        @(negedge clk);
        chk("midrst_position", 32'(position), 32'd0);
        chk("midrst_period", 32'(period), 32'd0);
        chk("midrst_period_valid", 32'(period_valid), 32'd0);
        chk("midrst_step_evt", 32'(step_evt), 32'd0);
        chk("midrst_err_dir", 32'(err_dir), 32'd0);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("midrst_no_step_position", 32'(position), 32'd0);

        repeat (5) @(negedge clk);
        chk("leftover_predictions", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/step_decoder.md
STEP_DECODER -- requirements
Module: step_decoder

Interface
REQ-001 Parameter W, default 16: width of the position counter.
REQ-002 Parameter T, default 5: width of the timing inputs filt_len and dirtime.
REQ-003 Parameter P, default 16: width of the step-period counter.
REQ-004 clk  in  1  single clock; all logic is on posedge clk.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 enable  in  1  when low, freezes counting and error checks.
REQ-007 step_in  in  1  asynchronous step pulse input.
REQ-008 dir_in  in  1  asynchronous direction input; 1 = up, 0 = down.
REQ-009 step_pol  in  1  selects the active edge: 0 = rising edge of step, 1 = falling edge.
REQ-010 filt_len  in  T  glitch-filter length in clocks.
REQ-011 dirtime  in  T  minimum dir setup before the active edge, in clocks.
REQ-012 err_clr  in  1  clears err_dir.
REQ-013 position  out  W  signed step count.
REQ-014 period  out  P  clocks between the last two active edges.
REQ-015 period_valid  out  1  period holds a valid measurement.
REQ-016 step_evt  out  1  one-cycle pulse per counted step.
REQ-017 err_dir  out  1  sticky dir setup/hold violation flag.

Function
REQ-018 step_in and dir_in SHALL each pass a 2-flop synchronizer, then a glitch filter.
REQ-019 Filter rule: the filtered level SHALL take the synchronized value only after that value differs from the filtered level for filt_len+1 consecutive clocks.
- Any reversion to the filtered level during the count restarts the count.
- filt_len=0 gives a pass-through of 1 cycle.
REQ-020 The active edge SHALL be detected on filtered step per step_pol.
- step_evt pulses high for 1 cycle, exactly filt_len+3 clocks after the first clock edge that samples the new step_in level.
REQ-021 On step_evt, position SHALL add +1 if filtered dir=1, else -1.
- Arithmetic is modulo 2^W; 2^W-1 +1 wraps to 0, and 0 -1 wraps to all-ones.
REQ-022 Dir FSM states:
- SETTLE: filtered dir changed; load a down-counter with dirtime.
- READY: down-counter reached 0.
- Transitions: SETTLE->READY when the counter is 0; any filtered dir change returns to SETTLE.
REQ-023 An active edge while the FSM is in SETTLE SHALL set err_dir; the step is still counted using the new dir.
REQ-024 A filtered dir change while filtered step is at its active level (the hold violation) SHALL set err_dir.
REQ-025 err_dir SHALL be cleared by err_clr; when a set and err_clr occur in the same cycle, the set wins.
REQ-026 Period counter: increments every enabled clock and saturates at 2^P-1.
- On step_evt: period <= counter value + 1, then the counter resets to 0.
REQ-027 period_valid SHALL rise on the second step_evt after reset.
- It clears when the counter saturates.
- It sets again on the second step_evt after saturation.
REQ-028 enable=0 SHALL hold position, the period counter, the filter counts, the dir FSM and err_dir.
- The synchronizers keep sampling.
- step_evt is forced to 0.
REQ-029 A simultaneous step edge and dir change at the inputs SHALL be resolved after filtering; equal filter latencies make the edge see the new dir and flag err_dir when dirtime>0.

Reset
REQ-030 When rst_n=0 at a clock edge, the following SHALL all be 0: position, period, period_valid, step_evt, err_dir, the filter counts and the period counter.
- Filtered levels take 0 (step at the inactive level for step_pol=0).
- The dir FSM goes to READY.
REQ-031 Reset asserted mid-filter or mid-SETTLE SHALL abort the operation, with no step counted.

Structure
REQ-032 The shared package stepgen_pkg SHALL hold:
- the dir FSM state encoding (SETTLE, READY);
- default W, T and P.
REQ-033 One sub-module, sig_filter (synchronizer plus glitch filter, width T), SHALL be instantiated twice: for step and for dir.

Verification
REQ-034 filt_len=2, step_pol=0, dir=1 held stable; one step_in pulse 8 clocks wide -> step_evt exactly 5 clocks after the rising edge is sampled; position=1.
REQ-035 filt_len=3; step_in glitch 3 clocks wide -> no step_evt and position unchanged; a 4-clock pulse -> counted.
REQ-036 position=16'hFFFF, dir=1, one step -> position=0; then dir=0 and one step -> 16'hFFFF.
REQ-037 dirtime=4; dir toggled 2 clocks before the step edge -> err_dir=1, step counted down; err_clr pulsed on the same cycle as a new violation -> err_dir stays 1.
REQ-038 Steps 100 clocks apart -> period=100 and period_valid=1 after the 2nd step; P=8 with a 300-clock gap -> period_valid=0.
REQ-039 rst_n=0 for 1 clock during a filter count -> all outputs 0, and no step_evt follows.
